// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sharing controller: ALU ctrl codes, FSM states
// and the legal-op check used when ALU_OP_CHECK_EN is defined.
package alu_pkg;
  localparam int ALU_CTRL_W = 4;

  localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'd0;
  localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'd1;
  localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'd2;
  localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'd6;
  localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'd7;
  localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'd12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic alu_op_legal(input logic [ALU_CTRL_W-1:0] ctrl);
    return ctrl inside {ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the requester favoured on a tie
// and only moves when a grant is actually taken (advance).
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);
  logic ptr;

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        ptr <= 1'b0;
    else if (advance) ptr <= ~grant[1];
  end
endmodule

// File: rtl/alu_share_ctrl.sv
// Sequences one external ALU between two requesters, one op outstanding at a time.
// Optional ALU_OP_CHECK_EN: illegal ctrl codes bypass the ALU and return rsp_err_o=1.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = ALU_CTRL_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [CTRL_W-1:0] req0_ctrl_i,
  input  logic [DATA_W-1:0] req0_src1_i,
  input  logic [DATA_W-1:0] req0_src2_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [CTRL_W-1:0] req1_ctrl_i,
  input  logic [DATA_W-1:0] req1_src1_i,
  input  logic [DATA_W-1:0] req1_src2_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic              alu_zero_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic              rsp_id_o,
  output logic [DATA_W-1:0] rsp_result_o,
  output logic              rsp_zero_o,
  output logic              rsp_err_o,
  output logic              busy_o
);
  state_t            state;
  logic [1:0]        grant;
  logic              hs;
  logic              sel_id;
  logic [CTRL_W-1:0] sel_ctrl;
  logic [DATA_W-1:0] sel_src1, sel_src2;

  logic [CTRL_W-1:0] op_ctrl;
  logic [DATA_W-1:0] op_src1, op_src2;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  rr_arb2 u_arb (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .valid   ({req1_valid_i, req0_valid_i}),
    .advance (hs),
    .grant   (grant)
  );

  assign req0_ready_o = (state == ST_IDLE) & grant[0];
  assign req1_ready_o = (state == ST_IDLE) & grant[1];
  assign hs           = req0_ready_o | req1_ready_o;

  assign sel_id   = grant[1];
  assign sel_ctrl = sel_id ? req1_ctrl_i : req0_ctrl_i;
  assign sel_src1 = sel_id ? req1_src1_i : req0_src1_i;
  assign sel_src2 = sel_id ? req1_src2_i : req0_src2_i;

`ifdef ALU_OP_CHECK_EN
  logic rsp_err;
  logic sel_legal;
  assign sel_legal = alu_op_legal(ALU_CTRL_W'(sel_ctrl));
  assign rsp_err_o = rsp_err;
`else
  assign rsp_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      op_ctrl    <= '0;
      op_src1    <= '0;
      op_src2    <= '0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      rsp_err    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: if (hs) begin
          rsp_id <= sel_id;
`ifdef ALU_OP_CHECK_EN
          // illegal codes never reach the ALU; op regs keep the previous op
          if (!sel_legal) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
            state      <= ST_RESP;
          end else begin
`else
          begin
`endif
            op_ctrl <= sel_ctrl;
            op_src1 <= sel_src1;
            op_src2 <= sel_src2;
            state   <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result_i;
          rsp_zero   <= alu_zero_i;
`ifdef ALU_OP_CHECK_EN
          rsp_err    <= 1'b0;
`endif
          state      <= ST_RESP;
        end
        ST_RESP: if (rsp_ready_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign alu_ctrl_o   = op_ctrl;
  assign alu_src1_o   = op_src1;
  assign alu_src2_o   = op_src2;
  assign rsp_valid_o  = (state == ST_RESP);
  assign rsp_id_o     = rsp_id;
  assign rsp_result_o = rsp_result;
  assign rsp_zero_o   = rsp_zero;
  assign busy_o       = (state != ST_IDLE);
endmodule
